// File: rtl/alu_pkg.sv
// Shared ALU definitions: result record layout and default sizes for the
// result FIFO that sits directly downstream of the ALU.
package alu_pkg;

   localparam int ALU_WIDTH      = 8;
   localparam int RES_FIFO_DEPTH = 8;

   // Saturation ceiling of the dropped-result counter
   localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

   // One ALU result as stored in the FIFO: carry on top, data below
   typedef struct packed {
      logic                 carry;
      logic [ALU_WIDTH-1:0] out;
   } alu_res_t;

endpackage

// File: rtl/alu_res_mem.sv
// Result storage: DEPTH x alu_res_t, one synchronous write port and one
// asynchronous (combinational) read port for first-word fall-through.
// Contents are deliberately not reset.
module alu_res_mem
   import alu_pkg::*;
#(
   parameter int DEPTH = RES_FIFO_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  alu_res_t      wdata_i,
   input  logic [AW-1:0] raddr_i,
   output alu_res_t      rdata_o
);

   alu_res_t mem_q [DEPTH];

   // Write the accepted result into its slot
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: captures {carry, out} on every ALU ready strobe, presents
// the oldest entry combinationally, and counts results lost while full.
// A full FIFO still accepts a strobe when the head is popped the same cycle.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = RES_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   alu_ready,
   input  logic [WIDTH-1:0]       alu_out,
   input  logic                   alu_carry,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [WIDTH-1:0]       res_data,
   output logic                   res_carry,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   input  logic                   clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   // Storage is typed by alu_res_t, so the data width must match the ALU
   if (WIDTH != ALU_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("alu_result_fifo: WIDTH must equal ALU_WIDTH and DEPTH must be a power of two >= 2");
   end

   // Saturating increment of the drop counter
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == DROP_CNT_MAX) ? DROP_CNT_MAX : v + 8'd1;
   endfunction

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   logic     push;
   logic     pop;
   logic     drop;
   alu_res_t wr_res;
   alu_res_t rd_res;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);
   assign res_valid = ~empty;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

   assign pop  = res_valid & res_ready;
   assign push = alu_ready & (~full | pop);
   assign drop = alu_ready & full & ~pop;

   assign wr_res.carry = alu_carry;
   assign wr_res.out   = alu_out;

   assign res_data  = rd_res.out;
   assign res_carry = rd_res.carry;

   alu_res_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_res),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_res)
   );

   // Next-state for pointers, occupancy and drop bookkeeping
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear wins and restarts the count at 1
      if (drop) begin
         overflow_d = 1'b1;
         drop_cnt_d = clr_ovf ? 8'd1 : sat_inc(drop_cnt_q);
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // Control state; reset empties the FIFO immediately
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_alu_result_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             nrst;
   logic             alu_ready;
   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic [3:0]       count;
   logic             full;
   logic             empty;
   logic             overflow;
   logic [7:0]       drop_cnt;
   logic             clr_ovf;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: queue of {carry, data}, sticky flag, saturating counter
   logic [WIDTH:0] m_q[$];
   bit             m_ovf;
   int             m_drop;

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .alu_ready (alu_ready),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_carry (res_carry),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = m_q.size();
      check("res_valid", 32'(res_valid), 32'(sz != 0));
      check("count",     32'(count),     32'(sz));
      check("full",      32'(full),      32'(sz == DEPTH));
      check("empty",     32'(empty),     32'(sz == 0));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
      if (sz != 0) begin
         check("res_data",  32'(res_data),  32'(m_q[0][WIDTH-1:0]));
         check("res_carry", 32'(res_carry), 32'(m_q[0][WIDTH]));
      end
   endtask

   // One clock: apply inputs, check current outputs, then advance model and DUT
   task automatic cycle(input bit ar, input logic [WIDTH-1:0] d, input bit c,
                        input bit rr, input bit clr);
      bit do_pop, do_push, do_drop;
      alu_ready = ar;
      alu_out   = d;
      alu_carry = c;
      res_ready = rr;
      clr_ovf   = clr;
      #1;
      check_outputs();
      do_pop  = (m_q.size() != 0) && rr;
      do_push = ar && ((m_q.size() < DEPTH) || do_pop);
      do_drop = ar && (m_q.size() == DEPTH) && !do_pop;
      @(posedge clk);
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back({c, d});
      if (do_drop) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
      end else if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      #1;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      nrst      = 1'b0;
      alu_ready = 1'b1;
      alu_out   = 8'hEE;
      alu_carry = 1'b1;
      res_ready = 1'b0;
      clr_ovf   = 1'b0;
      model_reset();

      // Reset state while nrst is held low, with a strobe present
      #2;
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      #5 nrst = 1'b1;      // release away from the clock edge
      @(posedge clk);
      #1;
      alu_ready = 1'b0;
      // The strobe held high across that edge was a legal push
      m_q.push_back({1'b1, 8'hEE});
      drain();

      // Three strobes held, then popped in order
      cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      check("count_after_3", 32'(count), 32'd3);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("empty_after_drain3", 32'(empty), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);   // ready while empty is harmless

      // Nine strobes into eight slots: last one dropped
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), i[0], 1'b0, 1'b0);
      check("drop_after_9", 32'(drop_cnt), 32'd1);
      // Full with a simultaneous pop: appended, nothing dropped
      cycle(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
      check("count_full_pop", 32'(count), 32'd8);
      drain();

      // Saturation of the drop counter, then clear
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      check("drop_sat", 32'(drop_cnt), 32'd255);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared", 32'(overflow), 32'd0);
      // Clear and drop together: drop wins
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
      check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
      drain();

      // Steady state push/pop with alternating carry; pointers wrap
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), i[0], 1'b1, 1'b0);
      drain();

      // Asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
      alu_ready = 1'b0;
      nrst = 1'b0;
      #2;
      model_reset();
      check("rst_count_now", 32'(count), 32'd0);
      check("rst_valid_now", 32'(res_valid), 32'd0);
      #3 nrst = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("after_rst_head", 32'(res_data), 32'hA5);
      drain();

      // Random traffic with phases biased toward filling and draining
      for (int i = 0; i < 3000; i++) begin
         int pp, pr;
         pp = ((i / 250) % 2 == 0) ? 75 : 35;
         pr = ((i / 250) % 2 == 0) ? 35 : 75;
         cycle($urandom_range(0, 99) < pp, 8'($urandom), 1'($urandom),
               $urandom_range(0, 99) < pr, $urandom_range(0, 39) == 0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter WIDTH, default 8: ALU operand/result width; SHALL equal the ALU `out` width.
REQ-002 Parameter DEPTH, default 8: result entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 alu_ready  input  1  ALU result strobe; high = alu_out/alu_carry are valid this cycle.
REQ-006 alu_out  input  WIDTH  ALU result.
REQ-007 alu_carry  input  1  ALU carry.
REQ-008 res_valid  output  1  head entry is available.
REQ-009 res_ready  input  1  consumer accepts the head entry.
REQ-010 res_data  output  WIDTH  head result.
REQ-011 res_carry  output  1  head carry.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 overflow  output  1  sticky flag: a result was dropped.
REQ-016 drop_cnt  output  8  number of dropped results, saturating.
REQ-017 clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-018 Push: a push SHALL occur in every cycle where alu_ready=1 and the FIFO is not full, or it is full and a pop occurs in the same cycle. The push stores {alu_carry, alu_out} at the write pointer.
REQ-019 Pop: a pop SHALL occur in every cycle where res_valid=1 and res_ready=1; the read pointer advances by one.
REQ-020 res_valid SHALL equal !empty.
REQ-021 res_data and res_carry SHALL present the head entry combinationally from storage (first-word fall-through); when empty they are don't-care.
REQ-022 Latency: a push into an empty FIFO SHALL raise res_valid in the next cycle; there is no same-cycle bypass.
REQ-023 count SHALL change by +1 for push only, -1 for pop only, and 0 for push and pop together or neither.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty SHALL be derived from count.
REQ-025 Drop: when alu_ready=1, full=1 and there is no pop, the result SHALL be discarded and storage left unchanged; overflow is set to 1 and drop_cnt increments, saturating at 255.
REQ-026 When clr_ovf=1 and a drop occur in the same cycle, the drop SHALL win: overflow=1 and drop_cnt=1.
REQ-027 res_ready while empty SHALL have no effect.
REQ-028 The entry order SHALL be strictly first-in, first-out; no entry is ever duplicated or reordered.

Reset
REQ-029 While nrst=0, pointers and count SHALL be 0, empty=1, full=0, res_valid=0, overflow=0 and drop_cnt=0; storage contents are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); the first push after deassertion lands at slot 0.
REQ-031 alu_ready SHALL be ignored in the first clock edge on which nrst is sampled high only if it coincides with the deassertion edge; from the next edge pushes are accepted normally.

Structure
REQ-032 The shared alu_pkg SHALL hold the packed struct alu_res_t {carry, out} and the constants ALU_WIDTH=8 and RES_FIFO_DEPTH=8.
REQ-033 Storage SHALL be one sub-module, alu_res_mem: DEPTH x alu_res_t, with a single write port and an asynchronous read port.
REQ-034 The block SHALL sit directly downstream of the ALU and connect to its out, carry and ready ports; clk and nrst are shared with the ALU.

Verification
REQ-035 Reset, then 3 strobes with out=0x11/0x22/0x33 and res_ready=0 -> count=3; then res_ready=1 -> 0x11, 0x22, 0x33 popped on consecutive cycles, empty=1 afterwards.
REQ-036 DEPTH=8: 9 strobes with no pop -> full=1, 9th value dropped, overflow=1, drop_cnt=1; the 8 stored values drain in order.
REQ-037 Full plus a strobe with a simultaneous pop -> count stays 8, the new value is appended and nothing is dropped.
REQ-038 300 strobes while full with no pop -> drop_cnt=255; then clr_ovf=1 -> overflow=0 and drop_cnt=0.
REQ-039 20 push/pop cycles at steady state with alu_carry alternating -> pointers wrap and the output sequence equals the input sequence.
REQ-040 Load 5 entries, then pulse nrst low for half a cycle -> count=0 and res_valid=0 immediately; the next strobe of 0xA5 is read back first.
